// File: rtl/maquina_cliente_pkg.sv
// Shared encodings for the vending-machine client: FSM states, response codes,
// and the bit positions of the switch and LED buses of the vending machine.
package maquina_cliente_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIME,
    ST_NICK,
    ST_ACT,
    ST_WAIT,
    ST_SETTLE,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    STATUS_VEND    = 2'b00,
    STATUS_REFUND  = 2'b01,
    STATUS_TIMEOUT = 2'b10
  } status_e;

  localparam int SW_W  = 4;
  localparam int SW_D  = 0;
  localparam int SW_N  = 1;
  localparam int SW_R  = 2;
  localparam int SW_P  = 3;

  localparam int LED_W      = 7;
  localparam int LED_CREDIT = 4;  // D1..D4 occupy led[LED_CREDIT-1:0]
  localparam int LED_P1     = 4;
  localparam int LED_N1     = 5;
  localparam int LED_R1     = 6;

  localparam logic [SW_W-1:0] MASK_D = 4'b0001 << SW_D;
  localparam logic [SW_W-1:0] MASK_N = 4'b0001 << SW_N;
  localparam logic [SW_W-1:0] MASK_R = 4'b0001 << SW_R;
  localparam logic [SW_W-1:0] MASK_P = 4'b0001 << SW_P;

endpackage

// File: rtl/maquina_cliente_boton.sv
// One simulated button press: the masked switch bits go high for PULSE_W cycles,
// then low for GAP cycles; done marks the last low cycle so a new start can follow.
module boton_pulso
  import maquina_cliente_pkg::*;
#(
  parameter int PULSE_W = 2,
  parameter int GAP     = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SW_W-1:0] mask,
  output logic [SW_W-1:0] pulse,
  output logic            done
);

  localparam int PERIOD = PULSE_W + GAP;
  localparam int CW     = $clog2(PERIOD + 1);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic [SW_W-1:0] pulse_q, pulse_d;

  assign done  = busy_q && (cnt_q == CW'(PERIOD - 1));
  assign pulse = pulse_q;

  always_comb begin
    // NOTE: every _d gets a default first so no path through the block leaves it unassigned (no latch).
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    pulse_d = pulse_q;
    if (start) begin
      busy_d  = 1'b1;
      cnt_d   = '0;
      pulse_d = mask;
    end else if (busy_q) begin
      if (done) begin
        busy_d  = 1'b0;
        pulse_d = '0;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        pulse_d = (cnt_d < CW'(PULSE_W)) ? pulse_q : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      pulse_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its neighbours.
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      pulse_q <= pulse_d;
    end
  end

endmodule

// File: rtl/maquina_cliente.sv
// Client that plays a coin/purchase sequence into a vending machine and reports
// how the machine answered (vend, refund or timeout), the credit and the change.
module maquina_cliente
  import maquina_cliente_pkg::*;
#(
  parameter int PULSE_W = 2,
  parameter int GAP     = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_dimes,
  input  logic [2:0]       req_nickels,
  input  logic             req_cancel,
  output logic [SW_W-1:0]  sw,
  input  logic [LED_W-1:0] led,
  output logic             rsp_valid,
  output logic [1:0]       rsp_status,
  output logic [2:0]       rsp_change,
  output logic [3:0]       rsp_credit
);

  localparam int CNT_MAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int TW      = $clog2(CNT_MAX + 1);

  state_e                  state_q, state_d;
  logic [2:0]              dimes_q, dimes_d;
  logic [2:0]              nickels_q, nickels_d;
  logic                    cancel_q, cancel_d;
  logic [TW-1:0]           cnt_q, cnt_d;
  status_e                 status_q, status_d;
  logic [2:0]              change_q, change_d;
  logic [3:0]              credit_q, credit_d;
  logic                    valid_q, valid_d;
  logic [LED_W-1:LED_P1]   led_hist_q, led_hist_d;

  logic                    start, press_done, launch, c_src;
  logic [SW_W-1:0]         mask;
  logic [2:0]              d_src, n_src;
  logic                    p1_rise, r1_rise, n1_rise;

  boton_pulso #(.PULSE_W(PULSE_W), .GAP(GAP)) u_boton (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mask  (mask),
    .pulse (sw),
    .done  (press_done)
  );

  assign req_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = valid_q;
  assign rsp_status = status_q;
  assign rsp_change = change_q;
  assign rsp_credit = credit_q;

  assign p1_rise = led[LED_P1] & ~led_hist_q[LED_P1];
  assign r1_rise = led[LED_R1] & ~led_hist_q[LED_R1];
  assign n1_rise = led[LED_N1] & ~led_hist_q[LED_N1];

  always_comb begin
    state_d    = state_q;
    dimes_d    = dimes_q;
    nickels_d  = nickels_q;
    cancel_d   = cancel_q;
    cnt_d      = cnt_q;
    status_d   = status_q;
    change_d   = change_q;
    credit_d   = credit_q;
    led_hist_d = led[LED_W-1:LED_P1];
    start      = 1'b0;
    mask       = '0;
    launch     = 1'b0;
    d_src      = '0;
    n_src      = '0;
    c_src      = cancel_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          cancel_d = req_cancel;
          change_d = '0;
          launch   = 1'b1;
          d_src    = req_dimes;
          n_src    = req_nickels;
          c_src    = req_cancel;
        end
      end
      ST_DIME: begin
        if (press_done) begin
          launch = 1'b1;
          d_src  = dimes_q;
          n_src  = nickels_q;
        end
      end
      ST_NICK: begin
        if (press_done) begin
          launch = 1'b1;
          n_src  = nickels_q;
        end
      end
      ST_ACT: begin
        if (press_done) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        // P1 is tested first so a simultaneous P1/R1 counts as a vend.
        if (p1_rise) begin
          state_d  = ST_SETTLE;
          status_d = STATUS_VEND;
          cnt_d    = '0;
        end else if (r1_rise) begin
          state_d  = ST_SETTLE;
          status_d = STATUS_REFUND;
          cnt_d    = '0;
        end else if (cnt_q == TW'(TIMEOUT)) begin
          state_d  = ST_RESP;
          status_d = STATUS_TIMEOUT;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == TW'(GAP - 1)) state_d = ST_RESP;
        else                       cnt_d   = cnt_q + TW'(1);
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Empty coin groups are skipped within the same edge, so no idle cycle is spent.
    if (launch) begin
      start = 1'b1;
      if (d_src != 3'd0) begin
        state_d   = ST_DIME;
        dimes_d   = d_src - 3'd1;
        nickels_d = n_src;
        mask      = MASK_D;
      end else if (n_src != 3'd0) begin
        state_d   = ST_NICK;
        nickels_d = n_src - 3'd1;
        mask      = MASK_N;
      end else begin
        state_d  = ST_ACT;
        credit_d = led[LED_CREDIT-1:0];
        mask     = c_src ? MASK_R : MASK_P;
      end
    end

    if ((state_q inside {ST_ACT, ST_WAIT, ST_SETTLE}) && n1_rise && (change_q != 3'd7))
      change_d = change_q + 3'd1;

    valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      dimes_q    <= '0;
      nickels_q  <= '0;
      cancel_q   <= 1'b0;
      cnt_q      <= '0;
      status_q   <= STATUS_VEND;
      change_q   <= '0;
      credit_q   <= '0;
      valid_q    <= 1'b0;
      led_hist_q <= '0;
    end else begin
      state_q    <= state_d;
      dimes_q    <= dimes_d;
      nickels_q  <= nickels_d;
      cancel_q   <= cancel_d;
      cnt_q      <= cnt_d;
      status_q   <= status_d;
      change_q   <= change_d;
      credit_q   <= credit_d;
      valid_q    <= valid_d;
      led_hist_q <= led_hist_d;
    end
  end

endmodule

// File: tb/tb_maquina_cliente.sv
// Self-checking bench: a vending-machine model drives led from a per-cycle schedule
// and the expected switch trace and response are derived arithmetically from it.
module tb_maquina_cliente;

  localparam int PW   = 2;
  localparam int GP   = 4;
  localparam int TO   = 255;
  localparam int PG   = PW + GP;
  localparam int MAXT = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_dimes = '0;
  logic [2:0] req_nickels = '0;
  logic       req_cancel = 1'b0;
  logic [3:0] sw;
  logic [6:0] led = '0;
  logic       rsp_valid;
  logic [1:0] rsp_status;
  logic [2:0] rsp_change;
  logic [3:0] rsp_credit;

  int n_checks = 0;
  int n_errors = 0;
  int prev_status = 0;
  int prev_change = 0;
  int prev_credit = 0;

  logic [3:0] d_arr  [MAXT];
  logic       n1_arr [MAXT];
  logic       p1_arr [MAXT];
  logic       r1_arr [MAXT];

  maquina_cliente #(.PULSE_W(PW), .GAP(GP), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_dimes   (req_dimes),
    .req_nickels (req_nickels),
    .req_cancel  (req_cancel),
    .sw          (sw),
    .led         (led),
    .rsp_valid   (rsp_valid),
    .rsp_status  (rsp_status),
    .rsp_change  (rsp_change),
    .rsp_credit  (rsp_credit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected sw in cycle t after the handshake: a train of d dime, n nickel and one action press.
  function automatic int exp_sw(int t, int d, int n, int c);
    int p, ph;
    if (t < 1 || t > (d + n + 1) * PG) return 0;
    p  = (t - 1) / PG;
    ph = (t - 1) % PG;
    if (ph >= PW)   return 0;
    if (p < d)      return 1;
    if (p < d + n)  return 2;
    return c ? 4 : 8;
  endfunction

  task automatic drive_led(input int t);
    led = {r1_arr[t], n1_arr[t], p1_arr[t], d_arr[t]};
  endtask

  task automatic clear_sched();
    for (int t = 0; t < MAXT; t++) begin
      d_arr[t]  = 4'($urandom);
      n1_arr[t] = 1'b0;
      p1_arr[t] = 1'b0;
      r1_arr[t] = 1'b0;
    end
  endtask

  // kind: 0 = P1, 1 = R1, 2 = no answer, 3 = P1 and R1 together.
  // delay: cycles from the start of the P/R press to the answer edge.
  // n1_off/n1_cnt: N1 pulses (1 high, 1 low) starting n1_off cycles after the P/R press.
  task automatic run_txn(input int d, input int n, input int c, input int kind,
                         input int delay, input int n1_off, input int n1_cnt, input string tag);
    int t_act, t_w, rise_t, resp_t, exp_status, exp_change, exp_credit, rises, idx;
    bit responded;
    t_act  = (d + n) * PG + 1;
    t_w    = t_act + PG;
    rise_t = t_act + delay;
    responded = (kind != 2) && (rise_t >= t_w) && (rise_t <= t_w + TO);
    resp_t = responded ? rise_t + GP + 1 : t_w + TO + 1;
    exp_status = !responded ? 2 : (kind == 1 ? 1 : 0);

    clear_sched();
    if (kind != 2) begin
      for (int t = rise_t; t < rise_t + 3 && t < MAXT; t++) begin
        if (kind != 1) p1_arr[t] = 1'b1;
        if (kind == 1 || kind == 3) r1_arr[t] = 1'b1;
      end
    end
    for (int k = 0; k < n1_cnt; k++) begin
      idx = t_act + n1_off + 2 * k;
      if (idx >= 1 && idx < MAXT) n1_arr[idx] = 1'b1;
    end
    rises = 0;
    for (int t = t_act; t < resp_t; t++)
      if (n1_arr[t] && !n1_arr[t-1]) rises++;
    exp_change = (rises > 7) ? 7 : rises;
    exp_credit = int'(d_arr[t_act-1]);

    @(posedge clk); #1;
    req_valid   = 1'b1;
    req_dimes   = 3'(d);
    req_nickels = 3'(n);
    req_cancel  = 1'(c);
    drive_led(0);
    @(negedge clk);
    check({tag, ".ready_hs"},  req_ready,  1);
    check({tag, ".hold_stat"}, rsp_status, prev_status);
    check({tag, ".hold_chg"},  rsp_change, prev_change);
    check({tag, ".hold_cred"}, rsp_credit, prev_credit);

    for (int t = 1; t <= resp_t; t++) begin
      @(posedge clk); #1;
      req_valid   = 1'($urandom);
      req_dimes   = 3'($urandom);
      req_nickels = 3'($urandom);
      req_cancel  = 1'($urandom);
      drive_led(t);
      @(negedge clk);
      check({tag, ".sw"},    sw,        exp_sw(t, d, n, c));
      check({tag, ".valid"}, rsp_valid, (t == resp_t) ? 1 : 0);
      check({tag, ".ready"}, req_ready, 0);
    end
    check({tag, ".status"}, rsp_status, exp_status);
    check({tag, ".change"}, rsp_change, exp_change);
    check({tag, ".credit"}, rsp_credit, exp_credit);
    req_valid   = 1'b0;
    prev_status = exp_status;
    prev_change = exp_change;
    prev_credit = exp_credit;
  endtask

  task automatic reset_mid_nick();
    clear_sched();
    @(posedge clk); #1;
    req_valid   = 1'b1;
    req_dimes   = 3'd2;
    req_nickels = 3'd3;
    req_cancel  = 1'b0;
    drive_led(0);
    @(negedge clk);
    check("rst.ready_hs", req_ready, 1);
    for (int t = 1; t <= 2 * PG + 2; t++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      drive_led(t);
      @(negedge clk);
      check("rst.pre_sw", sw, exp_sw(t, 2, 3, 0));
    end
    #1 rst = 1'b0;
    #1;
    check("rst.sw",     sw,         0);
    check("rst.valid",  rsp_valid,  0);
    check("rst.ready",  req_ready,  1);
    check("rst.change", rsp_change, 0);
    check("rst.credit", rsp_credit, 0);
    led = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      check("rst.after_valid", rsp_valid, 0);
      check("rst.after_sw",    sw,        0);
      check("rst.after_ready", req_ready, 1);
    end
    prev_status = 0;
    prev_change = 0;
    prev_credit = 0;
  endtask

  initial begin
    int d, n, c, kind, delay;
    #12;
    check("reset.sw",     sw,         0);
    check("reset.valid",  rsp_valid,  0);
    check("reset.status", rsp_status, 0);
    check("reset.change", rsp_change, 0);
    check("reset.credit", rsp_credit, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset.ready_after", req_ready, 1);

    run_txn(1, 1, 0, 0, 10, 0, 0, "p1_basic");
    run_txn(0, 0, 1, 1, PG + 2, 0, 0, "r1_refund");
    run_txn(0, 0, 0, 2, 0, 0, 0, "timeout");
    run_txn(0, 1, 0, 0, PG + 5, PG + 6, 2, "n1_settle");
    run_txn(1, 0, 0, 0, PG + 30, PG + 2, 10, "n1_sat");
    run_txn(2, 0, 0, 3, PG + 3, 0, 0, "p1_r1_same");
    run_txn(0, 0, 0, 0, PG + TO, 0, 0, "edge_last");
    run_txn(0, 0, 1, 1, PG + TO + 1, 0, 0, "edge_late");
    run_txn(0, 0, 0, 0, 2, 0, 0, "early_p1");
    run_txn(7, 7, 1, 1, PG, -2, 6, "max_counts");
    reset_mid_nick();
    run_txn(0, 2, 0, 0, PG + 1, -1, 3, "post_reset");

    for (int i = 0; i < 14; i++) begin
      d    = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 7);
      n    = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 7);
      c    = $urandom_range(0, 1);
      kind = ($urandom_range(0, 7) == 0) ? 2 : $urandom_range(0, 3);
      if (kind == 2) kind = ($urandom_range(0, 1) == 0) ? 2 : 3;
      delay = ($urandom_range(0, 5) == 0) ? PG + TO - 2 + $urandom_range(0, 3)
                                          : $urandom_range(PG - 2, PG + 40);
      run_txn(d, n, c, kind, delay, $urandom_range(0, 16) - 3, $urandom_range(0, 10), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/maquina_cliente.md
MAQUINA_CLIENTE -- requirements
Module: maquina_cliente

Interface
REQ-001 SHALL have parameter PULSE_W, default 2: cycles each simulated button press is held high.
REQ-002 SHALL have parameter GAP, default 4: low cycles after each press; also the settle window length.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum wait cycles for a machine response.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, 1 bit: purchase request offered.
REQ-007 SHALL have port req_ready, output, 1 bit: high only in IDLE.
REQ-008 SHALL have port req_dimes, input, 3 bits: dime presses to issue (0-7).
REQ-009 SHALL have port req_nickels, input, 3 bits: nickel presses to issue (0-7).
REQ-010 SHALL have port req_cancel, input, 1 bit: 1 = finish with refund (R), 0 = finish with purchase (P).
REQ-011 SHALL have port sw, output, 4 bits: {P,R,N,D} driven into the vending machine.
REQ-012 SHALL have port led, input, 7 bits: {R1,N1,P1,D4,D3,D2,D1} from the vending machine.
REQ-013 SHALL have port rsp_valid, output, 1 bit: single-cycle completion strobe.
REQ-014 SHALL have port rsp_status, output, 2 bits: 00 vended, 01 refunded, 10 timeout, 11 unused.
REQ-015 SHALL have port rsp_change, output, 3 bits: count of N1 rising edges seen, saturating at 7.
REQ-016 SHALL have port rsp_credit, output, 4 bits: D4..D1 sampled the cycle before the P/R press.

Function
REQ-017 SHALL register req_dimes, req_nickels and req_cancel on the handshake cycle (req_valid & req_ready); later input changes SHALL be ignored.
REQ-018 SHALL sequence states IDLE -> DIME -> NICK -> ACT -> WAIT -> SETTLE -> RESP -> IDLE.
REQ-019 DIME: SHALL issue req_dimes presses, each sw[0]=1 for PULSE_W cycles then 0 for GAP cycles; a count of 0 SHALL skip the state with no cycle spent.
REQ-020 NICK: SHALL issue presses on sw[1] in the same way; a count of 0 SHALL be skipped.
REQ-021 ACT: SHALL capture rsp_credit = led[3:0] on entry, then issue one press on sw[3] (P) or sw[2] (R, if req_cancel) with the same timing.
REQ-022 SHALL drive at most one sw bit high in any cycle.
REQ-023 WAIT: SHALL count cycles from 0; the first rising edge of led[4] (P1) or led[6] (R1) SHALL enter SETTLE.
REQ-024 WAIT: if the count reaches TIMEOUT with no edge, SHALL go to RESP with status 10.
REQ-025 P1 and R1 rising in the same cycle SHALL resolve to status 00 (P1 priority).
REQ-026 SETTLE: SHALL last GAP cycles then go to RESP; status 00 for P1, 01 for R1.
REQ-027 From ACT entry through the end of SETTLE, SHALL count rising edges of led[5] (N1) into rsp_change, cleared at the handshake and saturating at 7.
REQ-028 SHALL detect edges against a one-cycle registered copy of led.
REQ-029 RESP: SHALL assert rsp_valid for exactly one cycle, then return to IDLE.
REQ-030 rsp_status, rsp_change and rsp_credit SHALL hold until the next handshake.
REQ-031 A new request SHALL be accepted in the first IDLE cycle after RESP.

Reset
REQ-032 Asserting rst low SHALL immediately force state IDLE and clear the following: sw=0000, rsp_valid=0, rsp_status=00, rsp_change=0, rsp_credit=0, all counters, and the led history register.
REQ-033 Reset asserted mid-sequence SHALL abort the sequence with no rsp_valid.
REQ-034 req_ready SHALL be 1 in the first cycle after release.

Structure
REQ-035 A shared package SHALL hold the state encoding, the rsp_status codes, and the sw/led bit-index constants; the vending machine top SHALL use the same constants.
REQ-036 A sub-module boton_pulso SHALL generate the PULSE_W-high/GAP-low press timing with a start/done handshake, reused by DIME, NICK and ACT.

Verification
REQ-037 Bench: dimes=1, nickels=1, cancel=0, machine model raises P1 10 cycles after P -> sw[0] high 2 cycles, sw[1] high 2 cycles, sw[3] high 2 cycles, rsp_status=00, one rsp_valid.
REQ-038 Bench: dimes=0, nickels=0, cancel=1, model raises R1 -> first press is sw[2] in the cycle after the handshake, rsp_status=01, rsp_change=0.
REQ-039 Bench: model never responds -> rsp_valid exactly TIMEOUT+1 cycles after WAIT entry, rsp_status=10.
REQ-040 Bench: model pulses N1 twice after P1, inside SETTLE -> rsp_change=2; ten N1 pulses -> rsp_change=7.
REQ-041 Bench: P1 and R1 rise in the same cycle -> rsp_status=00.
REQ-042 Bench: rst low during NICK -> sw=0000 immediately, no rsp_valid, req_ready=1 after release.
